// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with NZCV flags and a valid/ready handshake on both sides.
// Single-cycle ops finish on the accept edge; MUL is a one-bit-per-cycle shift-add loop.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010, OP_OR  = 4'b0011,
    OP_EOR = 4'b0100, OP_LSL = 4'b0101, OP_LSR = 4'b0110, OP_ASR = 4'b0111,
    OP_ROR = 4'b1000, OP_MUL = 4'b1001
  } alu_op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   count_q, count_d;

  logic [SHW-1:0]   amt, amt_neg;
  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum_w, lsl_w, lsr_w, asr_w;
  logic [WIDTH-1:0] ror_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] acc_step;

  // Single-cycle datapath; shifts carry an extra bit to capture the last bit shifted out.
  always_comb begin
    amt     = b[SHW-1:0];
    amt_neg = '0 - amt;
    sub     = (ALUControl == OP_SUB);
    bx      = sub ? ~b : b;
    sum_w   = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
    lsl_w   = {1'b0, a} << amt;
    lsr_w   = {a, 1'b0} >> amt;
    asr_w   = $signed({a, 1'b0}) >>> amt;
    ror_w   = (a >> amt) | (a << amt_neg);
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum_w[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_EOR: alu_res = a ^ b;
      OP_LSL: begin
        alu_res = lsl_w[WIDTH-1:0];
        alu_c   = lsl_w[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_w[WIDTH:1];
        alu_c   = lsr_w[0];
      end
      OP_ASR: begin
        alu_res = asr_w[WIDTH:1];
        alu_c   = asr_w[0];
      end
      OP_ROR: begin
        alu_res = ror_w;
        alu_c   = (amt != '0) & ror_w[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUControl == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = '0;
          end else begin
            state_d = S_DONE;
            res_d   = alu_res;
            flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + SHW'(1);
        if (count_q == '1) begin
          state_d = S_DONE;
          res_d   = acc_step;
          flags_d = {acc_step[WIDTH-1], (acc_step == '0), 2'b00};
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Result    = res_q;
  assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8 with hand-computed vectors.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, r32;
  logic [3:0]  op32, f32;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, r8;
  logic [3:0]  op8, f8;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t v32 [19];
  vec_t v8  [4];

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32), .ALUControl(op32), .out_valid(ov32), .out_ready(or32),
    .Result(r32), .ALUFlags(f32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .ALUControl(op8), .out_valid(ov8), .out_ready(or8),
    .Result(r8), .ALUFlags(f8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit w8, input vec_t v, input string nm);
    int cyc;
    cyc = 0;
    while (!(w8 ? ir8 : ir32) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " in_ready"}, 32'(w8 ? ir8 : ir32), 32'd1);
    if (w8) begin
      a8 = v.a[7:0]; b8 = v.b[7:0]; op8 = v.op; iv8 = 1'b1;
    end else begin
      a32 = v.a; b32 = v.b; op32 = v.op; iv32 = 1'b1;
    end
    @(posedge clk); #1;
    // Scramble inputs after accept; the result must come from the latched values.
    iv8 = 1'b0; iv32 = 1'b0;
    a8 = ~v.a[7:0]; b8 = ~v.b[7:0]; op8 = 4'b0000;
    a32 = ~v.a; b32 = ~v.b; op32 = 4'b0000;
    cyc = 1;
    while (!(w8 ? ov8 : ov32) && cyc < 200) begin
      chk({nm, " busy in_ready"}, 32'(w8 ? ir8 : ir32), 32'd0);
      @(posedge clk); #1; cyc++;
    end
    chk({nm, " latency"}, 32'(cyc), 32'(v.lat));
    chk({nm, " Result"}, w8 ? 32'(r8) : r32, v.res);
    chk({nm, " flags"}, 32'(w8 ? f8 : f32), 32'(v.fl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    v32[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1};
    v32[1]  = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1};
    v32[2]  = '{4'b0110, 32'h0000000F, 32'h00000001, 32'h00000007, 4'b0010, 1};
    v32[3]  = '{4'b0111, 32'h80000010, 32'h00000004, 32'hF8000001, 4'b1000, 1};
    v32[4]  = '{4'b1001, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 4'b1000, 33};
    v32[5]  = '{4'b0001, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b1000, 1};
    v32[6]  = '{4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 1};
    v32[7]  = '{4'b0011, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100, 1};
    v32[8]  = '{4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 1};
    v32[9]  = '{4'b0101, 32'h80000001, 32'h00000021, 32'h00000002, 4'b0010, 1};
    v32[10] = '{4'b1000, 32'h00000003, 32'h00000000, 32'h00000003, 4'b0000, 1};
    v32[11] = '{4'b1000, 32'h00000003, 32'h00000001, 32'h80000001, 4'b1010, 1};
    v32[12] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1};
    v32[13] = '{4'b0000, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111, 1};
    v32[14] = '{4'b1010, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0100, 1};
    v32[15] = '{4'b1001, 32'h00001234, 32'h00000010, 32'h00012340, 4'b0000, 33};
    v32[16] = '{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 33};
    v32[17] = '{4'b0110, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000, 1};
    v32[18] = '{4'b0111, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b1000, 1};

    v8[0] = '{4'b0000, 32'h000000FF, 32'h00000001, 32'h00000000, 4'b0110, 1};
    v8[1] = '{4'b1000, 32'h00000001, 32'h00000001, 32'h00000080, 4'b1010, 1};
    v8[2] = '{4'b1111, 32'h00000012, 32'h00000034, 32'h00000000, 4'b0100, 1};
    v8[3] = '{4'b1001, 32'h0000000F, 32'h00000011, 32'h000000FF, 4'b1000, 9};

    reset_n = 1'b0;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; or32 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; op8  = '0; or8  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(ov32), 32'd0);
    chk("reset Result", r32, 32'h0);
    chk("reset flags", 32'(f32), 32'h0);
    chk("reset in_ready", 32'(ir32), 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 19; i++) run_op(1'b0, v32[i], $sformatf("v32[%0d]", i));
    for (int i = 0; i < 4; i++)  run_op(1'b1, v8[i], $sformatf("v8[%0d]", i));

    // Backpressure: result held while consumer stalls; new requests refused.
    or32 = 1'b0;
    run_op(1'b0, '{4'b0000, 32'h10, 32'h20, 32'h30, 4'b0000, 1}, "bp op");
    for (int k = 0; k < 10; k++) begin
      iv32 = 1'b1; a32 = 32'h1; b32 = 32'h1; op32 = 4'b0001;
      @(posedge clk); #1;
      chk($sformatf("bp out_valid %0d", k), 32'(ov32), 32'd1);
      chk($sformatf("bp Result %0d", k), r32, 32'h30);
      chk($sformatf("bp flags %0d", k), 32'(f32), 32'h0);
      chk($sformatf("bp in_ready %0d", k), 32'(ir32), 32'd0);
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", 32'(ov32), 32'd0);
    chk("bp release in_ready", 32'(ir32), 32'd1);

    // Reset asserted mid-MUL must clear outputs without waiting for a clock edge.
    a32 = 32'h0000FFFF; b32 = 32'h00010001; op32 = 4'b1001; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-mul in_ready", 32'(ir32), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(ov32), 32'd0);
    chk("async reset Result", r32, 32'h0);
    chk("async reset flags", 32'(f32), 32'h0);
    chk("async reset in_ready", 32'(ir32), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset out_valid", 32'(ov32), 32'd0);
    run_op(1'b0, '{4'b0000, 32'h2, 32'h3, 32'h5, 4'b0000, 1}, "post reset add");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
